fwnoc_host_ep: RTL and testbench
================================

Name: fwnoc_host_ep

Overview:
- Host-side endpoint that sits directly on a router's host port.
- TX path: takes a message descriptor plus payload words from the host, builds a one-flit header and streams header and payload into the router's host ingress (router hi_).
- RX path: consumes packets from the router's host egress (router he_), checks the destination, and hands header fields and payload to the host.
- Packets whose destination does not match this endpoint are discarded and counted.

Parameters:
X_ID, 0, 2-bit X coordinate of this endpoint; placed in header src_x, compared against rx dst_x.
Y_ID, 0, 2-bit Y coordinate of this endpoint; placed in header src_y, compared against rx dst_y.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
tx_hdr_valid  in  1  host descriptor valid
tx_hdr_ready  out  1  descriptor accepted
tx_hdr_dst_x  in  2  destination X
tx_hdr_dst_y  in  2  destination Y
tx_hdr_len  in  8  payload word count, 0..255
tx_hdr_tag  in  16  user tag
tx_dat  in  32  payload word
tx_valid  in  1  payload valid
tx_ready  out  1  payload accepted
rt_o_dat  out  32  flit to router host ingress
rt_o_valid  out  1  flit valid
rt_o_ready  in  1  router accepts flit
rt_i_dat  in  32  flit from router host egress
rt_i_valid  in  1  flit valid
rt_i_ready  out  1  endpoint accepts flit
rx_hdr_valid  out  1  received header valid
rx_hdr_ready  in  1  host accepts header
rx_hdr_src_x  out  2  sender X
rx_hdr_src_y  out  2  sender Y
rx_hdr_len  out  8  payload word count
rx_hdr_tag  out  16  tag
rx_dat  out  32  payload word
rx_valid  out  1  payload valid
rx_ready  in  1  host accepts payload
rx_drop_cnt  out  16  saturating count of misrouted packets

Behaviour:
- Header flit layout:
  - [1:0] dst_x, [3:2] dst_y, [5:4] src_x, [7:6] src_y
  - [15:8] len, [31:16] tag
- All handshakes are valid/ready.
  - A transfer occurs on a rising clock edge when valid && ready.
  - Once asserted, valid and data stay stable until the transfer.
- Reset: both FSMs go to their idle state and rx_drop_cnt=0.
  - Reset-value outputs: tx_hdr_ready=1, rt_i_ready=1; all other valid/ready outputs 0; data/field outputs 0.
- TX FSM (states T_IDLE, T_HDR, T_PAY):
  - T_IDLE: tx_hdr_ready=1, tx_ready=0, rt_o_valid=0. On descriptor transfer, register the header and len into a remaining-word counter, then go to T_HDR. The header appears on rt_o one cycle after the descriptor transfer.
  - T_HDR: rt_o_valid=1, rt_o_dat=header, tx_hdr_ready=0. On rt_o transfer, go to T_PAY if len!=0, else T_IDLE.
  - T_PAY: combinational pass-through. rt_o_valid=tx_valid, rt_o_dat=tx_dat, tx_ready=rt_o_ready. Each transfer decrements the counter; the transfer with counter==1 returns to T_IDLE.
  - tx_valid is ignored outside T_PAY.
  - Back-to-back packets: at minimum one T_IDLE cycle between packets.
- RX FSM (states R_HDR, R_HOLD, R_PAY, R_DROP):
  - R_HDR: rt_i_ready=1. On transfer, register the header fields and load the counter with len.
    - If dst_x==X_ID and dst_y==Y_ID, go to R_HOLD.
    - Otherwise increment rx_drop_cnt (saturating at 0xFFFF), then go to R_DROP if len!=0, else stay in R_HDR.
  - R_HOLD: rx_hdr_valid=1, rt_i_ready=0. On rx_hdr transfer, go to R_PAY if len!=0, else R_HDR.
  - R_PAY: pass-through. rx_valid=rt_i_valid, rx_dat=rt_i_dat, rt_i_ready=rx_ready. Decrement per transfer; the last word returns to R_HDR.
  - R_DROP: rt_i_ready=1, words discarded, rx_valid=0. Decrement per transfer; the last word returns to R_HDR.
  - rx_hdr_* fields hold their value until the next header is captured.
- TX and RX paths are fully independent; simultaneous activity is allowed.
- Asynchronous reset mid-packet aborts both FSMs immediately with no flush; any partial packet is the system's responsibility.

Test Plan:
- X_ID=1,Y_ID=2: descriptor dst=(3,0), len=2, tag=0xBEEF, payload 0x11111111 and 0x22222222, rt_o_ready=1 → rt_o carries 0xBEEF0293, then 0x11111111, 0x22222222; tx_hdr_ready returns high after the last word.
- len=0 descriptor dst=(0,0), tag=0x0001 → exactly one flit 0x00010090, then T_IDLE.
- rt_o_ready toggling 1/0 during T_PAY, len=4 → 4 words delivered in order with none duplicated; tx_ready mirrors rt_o_ready.
- RX header 0x1234_0306 (dst=(2,1), src=(0,0), len=3) then 3 words, with X_ID=2,Y_ID=1 and rx_hdr_ready delayed 5 cycles → rx_hdr_tag=0x1234, rx_hdr_len=3; rt_i_ready=0 during the hold; the 3 words reach rx_dat in order.
- RX header dst=(0,3) with len=2, then 2 words, at endpoint (1,1) → rx_valid and rx_hdr_valid never assert; rx_drop_cnt=1; the next valid packet is delivered normally.
- Reset asserted in R_PAY and T_PAY mid-packet → outputs return to reset values asynchronously; after release, a fresh packet on each path completes correctly.

Source files
------------

// File: rtl/fwnoc_host_ep.sv
// Host endpoint on a router host port: frames host messages into
// header+payload flits on TX and filters and unpacks packets on RX.
module fwnoc_host_ep #(
  parameter logic [1:0] X_ID = 2'd0,
  parameter logic [1:0] Y_ID = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_hdr_valid,
  output logic        tx_hdr_ready,
  input  logic [1:0]  tx_hdr_dst_x,
  input  logic [1:0]  tx_hdr_dst_y,
  input  logic [7:0]  tx_hdr_len,
  input  logic [15:0] tx_hdr_tag,
  input  logic [31:0] tx_dat,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rt_o_dat,
  output logic        rt_o_valid,
  input  logic        rt_o_ready,
  input  logic [31:0] rt_i_dat,
  input  logic        rt_i_valid,
  output logic        rt_i_ready,
  output logic        rx_hdr_valid,
  input  logic        rx_hdr_ready,
  output logic [1:0]  rx_hdr_src_x,
  output logic [1:0]  rx_hdr_src_y,
  output logic [7:0]  rx_hdr_len,
  output logic [15:0] rx_hdr_tag,
  output logic [31:0] rx_dat,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_drop_cnt
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_HDR,
    T_PAY
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HDR,
    R_HOLD,
    R_PAY,
    R_DROP
  } rx_state_t;

  tx_state_t   tx_st;
  logic [31:0] tx_hdr_q;
  logic [7:0]  tx_cnt;

  rx_state_t   rx_st;
  logic [7:0]  rx_cnt;
  logic        rx_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_st    <= T_IDLE;
      tx_hdr_q <= '0;
      tx_cnt   <= '0;
    end else begin
      unique case (tx_st)
        T_IDLE: begin
          if (tx_hdr_valid) begin
            tx_hdr_q <= {tx_hdr_tag, tx_hdr_len,
                         Y_ID, X_ID,
                         tx_hdr_dst_y, tx_hdr_dst_x};
            tx_cnt   <= tx_hdr_len;
            tx_st    <= T_HDR;
          end
        end
        T_HDR: begin
          if (rt_o_ready)
            tx_st <= (tx_cnt != 8'd0) ? T_PAY : T_IDLE;
        end
        T_PAY: begin
          if (tx_valid && rt_o_ready) begin
            tx_cnt <= tx_cnt - 8'd1;
            if (tx_cnt == 8'd1)
              tx_st <= T_IDLE;
          end
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // Payload words flow straight through; only the header is buffered.
  assign tx_hdr_ready = (tx_st == T_IDLE);
  assign tx_ready     = (tx_st == T_PAY) && rt_o_ready;
  assign rt_o_valid   = (tx_st == T_HDR) ||
                        ((tx_st == T_PAY) && tx_valid);

  always_comb begin
    rt_o_dat = '0;
    unique case (tx_st)
      T_HDR:   rt_o_dat = tx_hdr_q;
      T_PAY:   rt_o_dat = tx_dat;
      default: rt_o_dat = '0;
    endcase
  end

  assign rx_hit = (rt_i_dat[1:0] == X_ID) &&
                  (rt_i_dat[3:2] == Y_ID);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_st        <= R_HDR;
      rx_cnt       <= '0;
      rx_hdr_src_x <= '0;
      rx_hdr_src_y <= '0;
      rx_hdr_len   <= '0;
      rx_hdr_tag   <= '0;
      rx_drop_cnt  <= '0;
    end else begin
      unique case (rx_st)
        R_HDR: begin
          if (rt_i_valid) begin
            rx_hdr_src_x <= rt_i_dat[5:4];
            rx_hdr_src_y <= rt_i_dat[7:6];
            rx_hdr_len   <= rt_i_dat[15:8];
            rx_hdr_tag   <= rt_i_dat[31:16];
            rx_cnt       <= rt_i_dat[15:8];
            if (rx_hit) begin
              rx_st <= R_HOLD;
            end else begin
              if (rx_drop_cnt != 16'hffff)
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
              rx_st <= (rt_i_dat[15:8] != 8'd0) ? R_DROP : R_HDR;
            end
          end
        end
        R_HOLD: begin
          if (rx_hdr_ready)
            rx_st <= (rx_cnt != 8'd0) ? R_PAY : R_HDR;
        end
        R_PAY: begin
          if (rt_i_valid && rx_ready) begin
            rx_cnt <= rx_cnt - 8'd1;
            if (rx_cnt == 8'd1)
              rx_st <= R_HDR;
          end
        end
        R_DROP: begin
          if (rt_i_valid) begin
            rx_cnt <= rx_cnt - 8'd1;
            if (rx_cnt == 8'd1)
              rx_st <= R_HDR;
          end
        end
        default: rx_st <= R_HDR;
      endcase
    end
  end

  assign rx_hdr_valid = (rx_st == R_HOLD);
  assign rx_valid     = (rx_st == R_PAY) && rt_i_valid;
  assign rx_dat       = (rx_st == R_PAY) ? rt_i_dat : 32'd0;

  always_comb begin
    rt_i_ready = 1'b0;
    unique case (rx_st)
      R_HDR:   rt_i_ready = 1'b1;
      R_DROP:  rt_i_ready = 1'b1;
      R_PAY:   rt_i_ready = rx_ready;
      default: rt_i_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fwnoc_host_ep.sv
// Bench for fwnoc_host_ep: stream-level packet model checked every
// cycle, plus literal flit/field expectations for directed packets.
module tb_fwnoc_host_ep;

  localparam logic [1:0] XI = 2'd1;
  localparam logic [1:0] YI = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        tx_hdr_valid, tx_hdr_ready;
  logic [1:0]  tx_hdr_dst_x, tx_hdr_dst_y;
  logic [7:0]  tx_hdr_len;
  logic [15:0] tx_hdr_tag;
  logic [31:0] tx_dat;
  logic        tx_valid, tx_ready;
  logic [31:0] rt_o_dat;
  logic        rt_o_valid, rt_o_ready;
  logic [31:0] rt_i_dat;
  logic        rt_i_valid, rt_i_ready;
  logic        rx_hdr_valid, rx_hdr_ready;
  logic [1:0]  rx_hdr_src_x, rx_hdr_src_y;
  logic [7:0]  rx_hdr_len;
  logic [15:0] rx_hdr_tag;
  logic [31:0] rx_dat;
  logic        rx_valid, rx_ready;
  logic [15:0] rx_drop_cnt;

  fwnoc_host_ep #(.X_ID(XI), .Y_ID(YI)) dut (
    .clock(clock), .reset(reset),
    .tx_hdr_valid(tx_hdr_valid), .tx_hdr_ready(tx_hdr_ready),
    .tx_hdr_dst_x(tx_hdr_dst_x), .tx_hdr_dst_y(tx_hdr_dst_y),
    .tx_hdr_len(tx_hdr_len), .tx_hdr_tag(tx_hdr_tag),
    .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rt_o_dat(rt_o_dat), .rt_o_valid(rt_o_valid),
    .rt_o_ready(rt_o_ready),
    .rt_i_dat(rt_i_dat), .rt_i_valid(rt_i_valid),
    .rt_i_ready(rt_i_ready),
    .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
    .rx_hdr_src_x(rx_hdr_src_x), .rx_hdr_src_y(rx_hdr_src_y),
    .rx_hdr_len(rx_hdr_len), .rx_hdr_tag(rx_hdr_tag),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model state: expected rt_o flits of the current packet and
  // the RX stream parser.
  logic [31:0] txq[$];
  int          tx_pos;
  logic [31:0] hq[$];
  logic [31:0] pq[$];
  int          rx_rem;
  bit          rx_deliver;
  int          drop_exp;
  logic [31:0] tx_log[$];
  logic [31:0] rx_log[$];
  logic [31:0] rxw[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout or unexpected event at %0t", nm, $time);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      txq.delete(); tx_pos = 0;
      hq.delete(); pq.delete();
      rx_rem = 0; rx_deliver = 0; drop_exp = 0;
    end else begin
      chk("tx_hdr_ready", 32'(tx_hdr_ready), 32'(txq.size() == 0));
      chk("rt_o_valid", 32'(rt_o_valid),
          (txq.size() == 0) ? 32'd0 :
          (tx_pos == 0) ? 32'd1 : 32'(tx_valid));
      chk("tx_ready", 32'(tx_ready),
          (txq.size() != 0 && tx_pos > 0) ? 32'(rt_o_ready) : 32'd0);
      chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(drop_exp));
      chk("rx_hdr_valid", 32'(rx_hdr_valid), 32'(hq.size() != 0));
      chk("rt_i_ready", 32'(rt_i_ready),
          (hq.size() != 0) ? 32'd0 :
          (rx_rem > 0 && rx_deliver) ? 32'(rx_ready) : 32'd1);
      chk("rx_valid", 32'(rx_valid),
          32'(hq.size() == 0 && rx_rem > 0 && rx_deliver && rt_i_valid));
      if (rt_o_valid && rt_o_ready) begin
        tx_log.push_back(rt_o_dat);
        if (txq.size() == 0) fail("rt_o_extra");
        else begin
          chk("rt_o_dat", rt_o_dat, txq.pop_front());
          tx_pos = (txq.size() == 0) ? 0 : tx_pos + 1;
        end
      end
      if (rt_i_valid && rt_i_ready) begin
        if (rx_rem == 0) begin
          rx_rem = int'(rt_i_dat[15:8]);
          rx_deliver = (rt_i_dat[1:0] == XI) && (rt_i_dat[3:2] == YI);
          if (rx_deliver) hq.push_back(rt_i_dat);
          else if (drop_exp < 65535) drop_exp++;
        end else begin
          rx_rem--;
          if (rx_deliver) pq.push_back(rt_i_dat);
        end
      end
      if (rx_hdr_valid && rx_hdr_ready) begin
        if (hq.size() == 0) fail("rx_hdr_extra");
        else begin
          chk("rx_hdr_src_x", 32'(rx_hdr_src_x), 32'(hq[0][5:4]));
          chk("rx_hdr_src_y", 32'(rx_hdr_src_y), 32'(hq[0][7:6]));
          chk("rx_hdr_len", 32'(rx_hdr_len), 32'(hq[0][15:8]));
          chk("rx_hdr_tag", 32'(rx_hdr_tag), 32'(hq[0][31:16]));
          void'(hq.pop_front());
        end
      end
      if (rx_valid && rx_ready) begin
        rx_log.push_back(rx_dat);
        if (pq.size() == 0) fail("rx_dat_extra");
        else chk("rx_dat", rx_dat, pq.pop_front());
      end
    end
  end

  task automatic tx_send(input logic [1:0] dx, input logic [1:0] dy,
                         input logic [7:0] len, input logic [15:0] tag,
                         input int nw, input bit toggle);
    bit got;
    int n;
    tx_hdr_dst_x = dx; tx_hdr_dst_y = dy;
    tx_hdr_len = len; tx_hdr_tag = tag;
    tx_hdr_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock); got = tx_hdr_ready;
      @(posedge clock); #1; n++;
    end while (!got && n < 100);
    tx_hdr_valid = 1'b0;
    if (!got) begin fail("tx_hdr_wait"); return; end
    txq.push_back({tag, len, YI, XI, dy, dx});
    for (int i = 0; i < int'(len); i++)
      txq.push_back(32'h11111111 * 32'(i + 1));
    for (int i = 0; i < nw; i++) begin
      tx_dat = 32'h11111111 * 32'(i + 1);
      tx_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clock); got = tx_ready;
        @(posedge clock); #1; n++;
        if (toggle) rt_o_ready = ~rt_o_ready;
      end while (!got && n < 100);
      if (!got) fail("tx_pay_wait");
    end
    tx_valid = 1'b0;
    rt_o_ready = 1'b1;
  endtask

  task automatic rx_send(input int nw);
    bit got;
    int n;
    for (int i = 0; i < nw; i++) begin
      rt_i_dat = rxw[i];
      rt_i_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clock); got = rt_i_ready;
        @(posedge clock); #1; n++;
      end while (!got && n < 100);
      if (!got) fail("rt_i_wait");
    end
    rt_i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((txq.size() != 0 || hq.size() != 0 || rx_rem != 0)
           && n < 200) begin
      @(posedge clock); n++;
    end
    if (n >= 200) fail("idle_wait");
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_hdr_ready", 32'(tx_hdr_ready), 32'd1);
    chk("rst_rt_i_ready", 32'(rt_i_ready), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rt_o_valid", 32'(rt_o_valid), 32'd0);
    chk("rst_rx_hdr_valid", 32'(rx_hdr_valid), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rt_o_dat", rt_o_dat, 32'd0);
    chk("rst_rx_dat", rx_dat, 32'd0);
    chk("rst_rx_hdr", {rx_hdr_tag, rx_hdr_len, rx_hdr_src_y,
                       rx_hdr_src_x, 4'd0}, 32'd0);
    chk("rst_drop_cnt", 32'(rx_drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    tx_hdr_valid = 0; tx_hdr_dst_x = 0; tx_hdr_dst_y = 0;
    tx_hdr_len = 0; tx_hdr_tag = 0; tx_dat = 0; tx_valid = 0;
    rt_o_ready = 1; rt_i_dat = 0; rt_i_valid = 0;
    rx_hdr_ready = 1; rx_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals();
    reset = 1'b0;

    // len=2 packet to (3,0)
    tx_log.delete();
    tx_send(2'd3, 2'd0, 8'd2, 16'hBEEF, 2, 1'b0);
    wait_idle();
    chk("t1_cnt", 32'(tx_log.size()), 32'd3);
    if (tx_log.size() == 3) begin
      chk("t1_hdr", tx_log[0], 32'hBEEF0293);
      chk("t1_w0", tx_log[1], 32'h11111111);
      chk("t1_w1", tx_log[2], 32'h22222222);
    end
    chk("t1_hdr_ready", 32'(tx_hdr_ready), 32'd1);

    // header-only packet
    tx_log.delete();
    tx_send(2'd0, 2'd0, 8'd0, 16'h0001, 0, 1'b0);
    wait_idle();
    chk("t2_cnt", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("t2_hdr", tx_log[0], 32'h00010090);

    // backpressure toggling during payload
    tx_log.delete();
    tx_send(2'd1, 2'd1, 8'd4, 16'hA5A5, 4, 1'b1);
    wait_idle();
    chk("t3_cnt", 32'(tx_log.size()), 32'd5);
    if (tx_log.size() == 5) begin
      chk("t3_hdr", tx_log[0], 32'hA5A50495);
      chk("t3_w0", tx_log[1], 32'h11111111);
      chk("t3_w3", tx_log[4], 32'h44444444);
    end

    // RX to this endpoint, header accept delayed 5 cycles
    rx_log.delete();
    rxw[0] = 32'h12340309; rxw[1] = 32'hAAAA0001;
    rxw[2] = 32'hBBBB0002; rxw[3] = 32'hCCCC0003;
    rx_hdr_ready = 1'b0;
    fork
      rx_send(4);
      begin
        n = 0;
        while (!rx_hdr_valid && n < 50) begin @(negedge clock); n++; end
        if (!rx_hdr_valid) fail("t4_hdr_valid");
        repeat (5) @(posedge clock);
        #1;
        chk("t4_hold_ready", 32'(rt_i_ready), 32'd0);
        chk("t4_tag", 32'(rx_hdr_tag), 32'h1234);
        chk("t4_len", 32'(rx_hdr_len), 32'd3);
        rx_hdr_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t4_cnt", 32'(rx_log.size()), 32'd3);
    if (rx_log.size() == 3) begin
      chk("t4_w0", rx_log[0], 32'hAAAA0001);
      chk("t4_w1", rx_log[1], 32'hBBBB0002);
      chk("t4_w2", rx_log[2], 32'hCCCC0003);
    end

    // misrouted packets (len 2, then len 0), then a good one
    rx_log.delete();
    rxw[0] = 32'h0000020C; rxw[1] = 32'hDEAD0001;
    rxw[2] = 32'hDEAD0002; rxw[3] = 32'h0000000F;
    rx_send(4);
    wait_idle();
    chk("t5_drop", 32'(rx_drop_cnt), 32'd2);
    chk("t5_none", 32'(rx_log.size()), 32'd0);
    rxw[0] = 32'h56780109; rxw[1] = 32'h0F0F0F0F;
    rx_send(2);
    wait_idle();
    chk("t5_tag", 32'(rx_hdr_tag), 32'h5678);
    chk("t5_cnt", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() == 1) chk("t5_w0", rx_log[0], 32'h0F0F0F0F);

    // reset mid-packet on both paths
    rxw[0] = 32'h43210409; rxw[1] = 32'h01010101;
    fork
      tx_send(2'd2, 2'd2, 8'd4, 16'h7777, 1, 1'b0);
      rx_send(2);
    join
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tx_log.delete();
    rx_log.delete();
    rxw[0] = 32'h9ABC0109; rxw[1] = 32'h13579BDF;
    fork
      tx_send(2'd3, 2'd3, 8'd1, 16'h4242, 1, 1'b0);
      rx_send(2);
    join
    wait_idle();
    chk("t6_tx_cnt", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      chk("t6_tx_hdr", tx_log[0], 32'h4242019F);
      chk("t6_tx_w0", tx_log[1], 32'h11111111);
    end
    chk("t6_rx_tag", 32'(rx_hdr_tag), 32'h9ABC);
    chk("t6_rx_cnt", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() == 1) chk("t6_rx_w0", rx_log[0], 32'h13579BDF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
